// File: rtl/synchronous_ram_fifo_controller_pkg.sv
// synchronous_ram_fifo_controller_pkg: default geometry shared by the FIFO controller and its users
package synchronous_ram_fifo_controller_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;
endpackage

// File: rtl/synchronous_ram_fifo_controller.sv
// synchronous_ram_fifo_controller: FWFT FIFO control for an external dual-port RAM with a registered read port
module synchronous_ram_fifo_controller
  import synchronous_ram_fifo_controller_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int DEPTH         = DEFAULT_DEPTH,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH),
  parameter int LEVEL_WIDTH   = ADDRESS_WIDTH + 1
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     write_enable,
  input  logic [WIDTH-1:0]         write_data,
  output logic                     full,
  input  logic                     read_enable,
  output logic [WIDTH-1:0]         read_data,
  output logic                     empty,
  output logic [LEVEL_WIDTH-1:0]   level,
  output logic                     ram_write_enable,
  output logic [ADDRESS_WIDTH-1:0] ram_write_address,
  output logic [WIDTH-1:0]         ram_write_data,
  output logic                     ram_read_enable,
  output logic [ADDRESS_WIDTH-1:0] ram_read_address,
  input  logic [WIDTH-1:0]         ram_read_data
);
  logic [ADDRESS_WIDTH:0] wp_q, wp_d, rp_q, rp_d, occ;
  logic hv_q, hv_d, ram_empty, push, pop, prefetch;
  // push is gated by resetn so the RAM sees no write while reset is held
  always_comb begin
    occ       = wp_q - rp_q;
    ram_empty = wp_q == rp_q;
    full      = wp_q == {~rp_q[ADDRESS_WIDTH], rp_q[ADDRESS_WIDTH-1:0]};
    push      = resetn && write_enable && !full;
    pop       = read_enable && hv_q;
    prefetch  = !ram_empty && (!hv_q || pop);
    wp_d      = push ? wp_q + 1'b1 : wp_q;
    rp_d      = prefetch ? rp_q + 1'b1 : rp_q;
    hv_d      = prefetch ? 1'b1 : (pop ? 1'b0 : hv_q);
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wp_q <= '0;
      rp_q <= '0;
      hv_q <= 1'b0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      hv_q <= hv_d;
    end
  end
  assign empty             = !hv_q;
  assign read_data         = ram_read_data;
  assign level             = LEVEL_WIDTH'(occ) + LEVEL_WIDTH'(hv_q);
  assign ram_write_enable  = push;
  assign ram_write_address = wp_q[ADDRESS_WIDTH-1:0];
  assign ram_write_data    = push ? write_data : '0;
  assign ram_read_enable   = prefetch;
  assign ram_read_address  = rp_q[ADDRESS_WIDTH-1:0];
endmodule

// File: tb/tb_synchronous_ram_fifo_controller.sv
// tb_synchronous_ram_fifo_controller: FIFO controller with a behavioural dual-port RAM, checked against a word-queue model
module tb_synchronous_ram_fifo_controller;
  localparam int W = 8, D = 16, AW = 4, LW = 5;
  logic clock = 0, resetn = 0, write_enable = 0, read_enable = 0;
  logic [W-1:0] write_data = '0, read_data, ram_write_data, ram_read_data;
  logic full, empty, ram_write_enable, ram_read_enable;
  logic [LW-1:0] level;
  logic [AW-1:0] ram_write_address, ram_read_address;
  logic [W-1:0] mem [D];
  typedef struct { logic [W-1:0] d; int t; } ent_t;
  ent_t q[$];
  int cyc = 0, npush = 0, n_assert = 0, n_fail = 0;

  always #5 clock = ~clock;

  synchronous_ram_fifo_controller #(.WIDTH(W), .DEPTH(D)) dut (
    .clock(clock), .resetn(resetn), .write_enable(write_enable), .write_data(write_data),
    .full(full), .read_enable(read_enable), .read_data(read_data), .empty(empty), .level(level),
    .ram_write_enable(ram_write_enable), .ram_write_address(ram_write_address),
    .ram_write_data(ram_write_data), .ram_read_enable(ram_read_enable),
    .ram_read_address(ram_read_address), .ram_read_data(ram_read_data));

  always @(posedge clock) if (ram_write_enable) mem[ram_write_address] <= ram_write_data;
  always @(posedge clock or negedge resetn)
    if (!resetn) ram_read_data <= '0;
    else if (ram_read_enable) ram_read_data <= mem[ram_read_address];

  // A word is presented at the head two cycles after its push, once it is the oldest word held.
  function automatic bit m_vis();
    return q.size() > 0 && q[0].t + 2 <= cyc;
  endfunction
  function automatic bit m_full();
    return (q.size() - int'(m_vis())) == D;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_state();
    chk("level", 32'(level), 32'(q.size()));
    chk("empty", 32'(empty), 32'(!m_vis()));
    chk("full", 32'(full), 32'(m_full()));
    if (m_vis()) chk("read_data", 32'(read_data), 32'(q[0].d));
  endtask

  task automatic cycle(bit we, logic [W-1:0] wd, bit re);
    bit v, f;
    @(negedge clock);
    check_state();
    v = m_vis();
    f = m_full();
    write_enable = we;
    write_data = wd;
    read_enable = re;
    #1;
    chk("ram_write_enable", 32'(ram_write_enable), 32'(we && !f));
    if (we && !f) begin
      chk("ram_write_address", 32'(ram_write_address), 32'(npush % D));
      chk("ram_write_data", 32'(ram_write_data), 32'(wd));
    end
    @(posedge clock);
    if (we && !f) begin
      q.push_back('{wd, cyc});
      npush++;
    end
    if (re && v) void'(q.pop_front());
    cyc++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 0);
  endtask

  task automatic reset_check();
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_read_data", 32'(read_data), 0);
    chk("rst_ram_we", 32'(ram_write_enable), 0);
    chk("rst_ram_wd", 32'(ram_write_data), 0);
    chk("rst_ram_re", 32'(ram_read_enable), 0);
    chk("rst_ram_ra", 32'(ram_read_address), 0);
  endtask

  initial begin
    write_enable = 1;
    write_data = 8'h5A;
    #2 reset_check();
    @(negedge clock);
    write_enable = 0;
    resetn = 1;
    idle(2);
    // single word, then pop
    cycle(1, 8'hA5, 0);
    idle(2);
    cycle(0, '0, 1);
    idle(1);
    // fill to capacity, overflow pushes dropped, then drain
    for (int i = 0; i <= D; i++) cycle(1, W'(i), 0);
    idle(2);
    chk("full_level", 32'(level), D + 1);
    for (int i = 0; i < 3; i++) cycle(1, 8'h99, 0);
    for (int i = 0; i < D + 4; i++) cycle(0, '0, 1);
    // pop while empty
    cycle(0, '0, 1);
    cycle(0, '0, 1);
    // streaming at one word per cycle
    for (int i = 0; i < 3; i++) cycle(1, W'($urandom), 0);
    idle(3);
    for (int i = 0; i < 100; i++) begin
      cycle(1, W'($urandom), 1);
      chk("stream_level", 32'(level), 3);
    end
    for (int i = 0; i < 6; i++) cycle(0, '0, 1);
    // push while full in isolation
    for (int i = 0; i < D + 3; i++) cycle(1, W'($urandom), 0);
    cycle(1, 8'hEE, 0);
    cycle(1, 8'hEE, 0);
    for (int i = 0; i < D + 3; i++) cycle(0, '0, 1);
    // random mix
    for (int i = 0; i < 300; i++) cycle(($urandom % 3) != 0, W'($urandom), ($urandom % 2) != 0);
    for (int i = 0; i < D + 4; i++) cycle(0, '0, 1);
    // reset mid-stream at level 5
    for (int i = 0; i < 5; i++) cycle(1, W'(8'h40 + i), 0);
    idle(2);
    chk("pre_reset_level", 32'(level), 5);
    @(negedge clock);
    write_enable = 1;
    write_data = 8'h77;
    resetn = 0;
    #1 reset_check();
    q.delete();
    npush = 0;
    @(negedge clock);
    resetn = 1;
    write_enable = 0;
    cycle(1, 8'h3C, 0);
    idle(2);
    chk("post_reset_head", 32'(read_data), 32'h3C);
    cycle(0, '0, 1);
    idle(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
